adc_dual_capture: RTL and testbench

ADC-side responder for the CAS conversion handshake. On each request from CAS (`START_ADC`), it runs one serial conversion frame on a pair of simultaneously-sampling 12-bit ADCs, one for current and one for voltage. It then presents the parallel results on `I`/`V` with a one-cycle `EOC` strobe. It sits between the board ADC pins and the CAS block's `I`, `V` and `EOC` inputs.

---
 rtl/adc_dual_capture.sv | 244 ++++++++++++++++++++++++
 tb/tb_adc_dual_capture.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_dual_capture.sv
// -----------------------------------------------------------------------------
// adc_dual_capture
//
// Serial-frame capture for a pair of simultaneously sampling ADCs (current and
// voltage) that share CS_N and SCLK. A rising edge on START_ADC requests one
// frame: four leading bits followed by WIDTH data bits, MSB first. Both channels
// are sampled on the cycle that drives SCLK 0->1. The parallel results appear on
// I/V together with a one-cycle EOC strobe.
//
// Optional feature (macro ADC_LEADING_ZERO_CHECK_EN):
//   defined     - the four leading bits of both channels must be zero. A frame
//                 that breaks this pulses FRAME_ERR instead of EOC, and I/V keep
//                 their previous values.
//   not defined - leading bits are discarded and FRAME_ERR is tied low.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous reset, active low
//   START_ADC  conversion request (edge detected)
//   SDATA_I    serial data, current ADC
//   SDATA_V    serial data, voltage ADC
//   CS_N       shared chip select, active low
//   SCLK       shared serial clock, idles high
//   I, V       last completed current / voltage sample
//   EOC        end-of-conversion strobe, one cycle
//   BUSY       high from SETUP until QUIET completes
//   FRAME_ERR  leading-bit error strobe, one cycle
// -----------------------------------------------------------------------------
module adc_dual_capture #(
   parameter int WIDTH     = 12,
   parameter int CLK_DIV   = 4,
   parameter int QUIET_CYC = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START_ADC,
   input  logic             SDATA_I,
   input  logic             SDATA_V,
   output logic             CS_N,
   output logic             SCLK,
   output logic [WIDTH-1:0] I,
   output logic [WIDTH-1:0] V,
   output logic             EOC,
   output logic             BUSY,
   output logic             FRAME_ERR
);

   localparam int FRAME_BITS = WIDTH + 4;
`ifdef ADC_LEADING_ZERO_CHECK_EN
   // Keep the leading bits so they can be inspected in DONE.
   localparam int SH_W = FRAME_BITS;
`else
   // Leading bits simply fall off the top of the shift register.
   localparam int SH_W = WIDTH;
`endif
   localparam int DIV_W  = $clog2(CLK_DIV) + 1;
   localparam int QCNT_W = $clog2(QUIET_CYC) + 1;

   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_ONE    = DIV_W'(1);
   localparam logic [QCNT_W-1:0] QUIET_LAST = QCNT_W'(QUIET_CYC - 1);
   localparam logic [QCNT_W-1:0] QUIET_ONE  = QCNT_W'(1);
   localparam logic [4:0]        BIT_LAST   = 5'(FRAME_BITS);
   localparam logic [4:0]        BIT_ONE    = 5'd1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_QUIET = 3'd4;

   logic [2:0]        state_q, state_d;
   logic              start_q;
   logic              pend_q, pend_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [4:0]        bit_q, bit_d;
   logic [QCNT_W-1:0] quiet_q, quiet_d;
   logic [SH_W-1:0]   sh_i_q, sh_i_d;
   logic [SH_W-1:0]   sh_v_q, sh_v_d;
   logic              cs_n_q, cs_n_d;
   logic              sclk_q, sclk_d;
   logic [WIDTH-1:0]  i_q, i_d;
   logic [WIDTH-1:0]  v_q, v_d;
   logic              eoc_q, eoc_d;
`ifdef ADC_LEADING_ZERO_CHECK_EN
   logic              ferr_q, ferr_d;
`endif
   logic              req_w;

   assign req_w = START_ADC & ~start_q;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      div_d   = div_q;
      bit_d   = bit_q;
      quiet_d = quiet_q;
      sh_i_d  = sh_i_q;
      sh_v_d  = sh_v_q;
      cs_n_d  = cs_n_q;
      sclk_d  = sclk_q;
      i_d     = i_q;
      v_d     = v_q;
      eoc_d   = 1'b0;
`ifdef ADC_LEADING_ZERO_CHECK_EN
      ferr_d  = 1'b0;
`endif

      // Every request lands in the one-deep flag first; a request seen while
      // the flag is already set is lost.
      if (req_w && !pend_q) begin
         pend_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            // Consuming the flag takes priority over a coincident new request,
            // which is therefore dropped.
            if (pend_q) begin
               pend_d  = 1'b0;
               state_d = ST_SETUP;
               cs_n_d  = 1'b0;
               sclk_d  = 1'b1;
               div_d   = '0;
            end
         end

         ST_SETUP: begin
            if (div_q == DIV_LAST) begin
               state_d = ST_SHIFT;
               div_d   = '0;
               bit_d   = '0;
               sclk_d  = 1'b0;   // low half-period comes first
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end

         ST_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (!sclk_q) begin
                  // Rising edge: capture both channels in this cycle.
                  sclk_d = 1'b1;
                  sh_i_d = {sh_i_q[SH_W-2:0], SDATA_I};
                  sh_v_d = {sh_v_q[SH_W-2:0], SDATA_V};
                  bit_d  = bit_q + BIT_ONE;
               end else if (bit_q == BIT_LAST) begin
                  // Last high half complete; SCLK stays high into idle.
                  state_d = ST_DONE;
                  cs_n_d  = 1'b1;
               end else begin
                  sclk_d = 1'b0;
               end
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end

         ST_DONE: begin
            state_d = ST_QUIET;
            quiet_d = '0;
`ifdef ADC_LEADING_ZERO_CHECK_EN
            if ((|sh_i_q[SH_W-1:WIDTH]) || (|sh_v_q[SH_W-1:WIDTH])) begin
               ferr_d = 1'b1;
            end else begin
               i_d   = sh_i_q[WIDTH-1:0];
               v_d   = sh_v_q[WIDTH-1:0];
               eoc_d = 1'b1;
            end
`else
            i_d   = sh_i_q[WIDTH-1:0];
            v_d   = sh_v_q[WIDTH-1:0];
            eoc_d = 1'b1;
`endif
         end

         ST_QUIET: begin
            if (quiet_q == QUIET_LAST) begin
               state_d = ST_IDLE;
            end else begin
               quiet_d = quiet_q + QUIET_ONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         pend_q  <= 1'b0;
         div_q   <= '0;
         bit_q   <= '0;
         quiet_q <= '0;
         sh_i_q  <= '0;
         sh_v_q  <= '0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b1;
         i_q     <= '0;
         v_q     <= '0;
         eoc_q   <= 1'b0;
`ifdef ADC_LEADING_ZERO_CHECK_EN
         ferr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         start_q <= START_ADC;
         pend_q  <= pend_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         quiet_q <= quiet_d;
         sh_i_q  <= sh_i_d;
         sh_v_q  <= sh_v_d;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         i_q     <= i_d;
         v_q     <= v_d;
         eoc_q   <= eoc_d;
`ifdef ADC_LEADING_ZERO_CHECK_EN
         ferr_q  <= ferr_d;
`endif
      end
   end

   assign CS_N = cs_n_q;
   assign SCLK = sclk_q;
   assign I    = i_q;
   assign V    = v_q;
   assign EOC  = eoc_q;
   assign BUSY = (state_q != ST_IDLE);
`ifdef ADC_LEADING_ZERO_CHECK_EN
   assign FRAME_ERR = ferr_q;
`else
   assign FRAME_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_adc_dual_capture.sv
// -----------------------------------------------------------------------------
// tb_adc_dual_capture
//
// Drives START_ADC requests and a pair of behavioural serial ADCs, and compares
// the observed CS_N falls, EOC / FRAME_ERR strobes (with I/V and SCLK rise
// counts) and BUSY falls against a reference schedule computed from the frame
// timing rules. Honours ADC_LEADING_ZERO_CHECK_EN like the design.
// -----------------------------------------------------------------------------
module tb_adc_dual_capture;

   localparam int WIDTH     = 12;
   localparam int CLK_DIV   = 4;
   localparam int QUIET_CYC = 8;

   // Timing rules, counted from the request-detect edge.
   localparam int CS_LAT   = 1;
   localparam int EOC_LAT  = 2 + 33 * CLK_DIV;
   // From CS_N fall to the first IDLE cycle (BUSY low).
   localparam int IDLE_OFS = (EOC_LAT - CS_LAT) + QUIET_CYC;

   typedef struct packed {
      int         cyc;
      logic [11:0] i;
      logic [11:0] v;
      int         rises;
   } ev_t;

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic             START_ADC = 1'b0;
   logic             SDATA_I = 1'b0;
   logic             SDATA_V = 1'b0;
   logic             CS_N, SCLK, EOC, BUSY, FRAME_ERR;
   logic [WIDTH-1:0] I, V;

   adc_dual_capture #(
      .WIDTH     (WIDTH),
      .CLK_DIV   (CLK_DIV),
      .QUIET_CYC (QUIET_CYC)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .START_ADC (START_ADC),
      .SDATA_I   (SDATA_I),
      .SDATA_V   (SDATA_V),
      .CS_N      (CS_N),
      .SCLK      (SCLK),
      .I         (I),
      .V         (V),
      .EOC       (EOC),
      .BUSY      (BUSY),
      .FRAME_ERR (FRAME_ERR)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   // ---------------- observed events ----------------
   int          obs_csf[$];
   ev_t         obs_eoc[$];
   ev_t         obs_fe[$];
   int          obs_bf[$];
   // ---------------- expected events ----------------
   int          exp_csf[$];
   ev_t         exp_eoc[$];
   ev_t         exp_fe[$];
   int          exp_bf[$];
   // words served by the ADC models, one per frame, in frame order
   logic [15:0] adc_i_q[$];
   logic [15:0] adc_v_q[$];

   int          last_csf;
   logic [11:0] mdl_i, mdl_v;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- ADC models + monitor ----------------
   logic        cs_prev = 1'b1, sclk_prev = 1'b1, busy_prev = 1'b0;
   logic [15:0] cur_i = '0, cur_v = '0;
   int          bit_idx = 0;
   int          rises = 0;

   always @(negedge CLK) begin
      if (cs_prev === 1'b1 && CS_N === 1'b0) begin
         obs_csf.push_back(cyc);
         if (adc_i_q.size() > 0) cur_i = adc_i_q.pop_front(); else cur_i = 16'hFFFF;
         if (adc_v_q.size() > 0) cur_v = adc_v_q.pop_front(); else cur_v = 16'hFFFF;
         bit_idx = 16;
         rises   = 0;
      end
      if (CS_N === 1'b0 && sclk_prev === 1'b0 && SCLK === 1'b1) rises++;
      // ADC output changes after each SCLK fall.
      if (CS_N === 1'b0 && sclk_prev === 1'b1 && SCLK === 1'b0 && bit_idx > 0) begin
         bit_idx--;
         SDATA_I = cur_i[bit_idx];
         SDATA_V = cur_v[bit_idx];
      end
      if (EOC === 1'b1) obs_eoc.push_back('{cyc, I, V, rises});
      if (FRAME_ERR === 1'b1) obs_fe.push_back('{cyc, I, V, rises});
      if (busy_prev === 1'b1 && BUSY === 1'b0) obs_bf.push_back(cyc);
      cs_prev   = CS_N;
      sclk_prev = SCLK;
      busy_prev = BUSY;
   end

   // ---------------- reference model ----------------
   task automatic mdl_reset();
      last_csf = -1000000;
      mdl_i = '0;
      mdl_v = '0;
      exp_csf.delete(); exp_eoc.delete(); exp_fe.delete(); exp_bf.delete();
      adc_i_q.delete(); adc_v_q.delete();
   endtask

   task automatic clear_obs();
      obs_csf.delete(); obs_eoc.delete(); obs_fe.delete(); obs_bf.delete();
   endtask

   // A request at edge r: dropped if a frame is already queued but not yet
   // started; otherwise starts right away or one cycle after the running
   // frame's QUIET ends.
   task automatic mdl_request(input int r, input logic [15:0] wi, input logic [15:0] wv);
      int c;
      int e;
      if (r <= last_csf) return;
      if (r >= last_csf + IDLE_OFS) c = r + CS_LAT;
      else c = last_csf + IDLE_OFS + 1;
      last_csf = c;
      adc_i_q.push_back(wi);
      adc_v_q.push_back(wv);
      exp_csf.push_back(c);
      e = c + EOC_LAT - CS_LAT;
`ifdef ADC_LEADING_ZERO_CHECK_EN
      if (wi[15:12] != 4'h0 || wv[15:12] != 4'h0) begin
         exp_fe.push_back('{e, mdl_i, mdl_v, 16});
      end else begin
         mdl_i = wi[11:0];
         mdl_v = wv[11:0];
         exp_eoc.push_back('{e, mdl_i, mdl_v, 16});
      end
`else
      mdl_i = wi[11:0];
      mdl_v = wv[11:0];
      exp_eoc.push_back('{e, mdl_i, mdl_v, 16});
`endif
      exp_bf.push_back(e + QUIET_CYC);
   endtask

   // Call at a falling clock edge; the request is detected on the next rising edge.
   task automatic request(input int hold, input logic [15:0] wi, input logic [15:0] wv);
      START_ADC = 1'b1;
      mdl_request(cyc + 1, wi, wv);
      repeat (hold) @(negedge CLK);
      START_ADC = 1'b0;
   endtask

   task automatic request_at(input int r, input int hold, input logic [15:0] wi, input logic [15:0] wv);
      while (cyc < r - 1) @(negedge CLK);
      request(hold, wi, wv);
   endtask

   task automatic settle();
      while (cyc < last_csf + IDLE_OFS + 10) @(negedge CLK);
      repeat (4) @(negedge CLK);
   endtask

   task automatic compare_all(input string tn);
      chk({tn, "_n_csfall"}, obs_csf.size(), exp_csf.size());
      for (int k = 0; k < exp_csf.size() && k < obs_csf.size(); k++)
         chk({tn, "_csfall_cyc"}, obs_csf[k], exp_csf[k]);
      chk({tn, "_n_eoc"}, obs_eoc.size(), exp_eoc.size());
      for (int k = 0; k < exp_eoc.size() && k < obs_eoc.size(); k++) begin
         chk({tn, "_eoc_cyc"}, obs_eoc[k].cyc, exp_eoc[k].cyc);
         chk({tn, "_eoc_i"}, obs_eoc[k].i, exp_eoc[k].i);
         chk({tn, "_eoc_v"}, obs_eoc[k].v, exp_eoc[k].v);
         chk({tn, "_sclk_rises"}, obs_eoc[k].rises, exp_eoc[k].rises);
      end
      chk({tn, "_n_ferr"}, obs_fe.size(), exp_fe.size());
      for (int k = 0; k < exp_fe.size() && k < obs_fe.size(); k++) begin
         chk({tn, "_ferr_cyc"}, obs_fe[k].cyc, exp_fe[k].cyc);
         chk({tn, "_ferr_i"}, obs_fe[k].i, exp_fe[k].i);
         chk({tn, "_ferr_v"}, obs_fe[k].v, exp_fe[k].v);
      end
      chk({tn, "_n_busyfall"}, obs_bf.size(), exp_bf.size());
      for (int k = 0; k < exp_bf.size() && k < obs_bf.size(); k++)
         chk({tn, "_busyfall_cyc"}, obs_bf[k], exp_bf[k]);
      chk({tn, "_hold_i"}, I, mdl_i);
      chk({tn, "_hold_v"}, V, mdl_v);
      clear_obs();
      exp_csf.delete(); exp_eoc.delete(); exp_fe.delete(); exp_bf.delete();
   endtask

   function automatic logic [15:0] rnd_word();
      logic [3:0]  lead;
      logic [11:0] data;
      lead = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      data = 12'($urandom);
      return {lead, data};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int r0;
      mdl_reset();

      // ---- reset state ----
      repeat (3) @(negedge CLK);
      chk("reset_cs_n", CS_N, 1'b1);
      chk("reset_sclk", SCLK, 1'b1);
      chk("reset_i", I, 12'h000);
      chk("reset_v", V, 12'h000);
      chk("reset_eoc", EOC, 1'b0);
      chk("reset_busy", BUSY, 1'b0);
      chk("reset_ferr", FRAME_ERR, 1'b0);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      clear_obs();

      // ---- basic frame ----
      request(1, 16'h0AAA, 16'h0555);
      settle();
      compare_all("basic");

      // ---- reset in the middle of a frame ----
      mdl_reset();
      clear_obs();
      adc_i_q.push_back(16'h0F0F);
      adc_v_q.push_back(16'h00F0);
      START_ADC = 1'b1;
      r0 = cyc + 1;
      @(negedge CLK);
      START_ADC = 1'b0;
      while (cyc < r0 + 50) @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("midrst_cs_n", CS_N, 1'b1);
      chk("midrst_sclk", SCLK, 1'b1);
      chk("midrst_i", I, 12'h000);
      chk("midrst_v", V, 12'h000);
      chk("midrst_busy", BUSY, 1'b0);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      repeat (200) @(negedge CLK);
      chk("midrst_no_eoc", obs_eoc.size(), 0);
      chk("midrst_no_ferr", obs_fe.size(), 0);
      mdl_reset();
      clear_obs();
      request(2, 16'h0ABC, 16'h0DEF);
      settle();
      compare_all("after_rst");

      // ---- held request: exactly one frame ----
      r0 = cyc + 1;
      request(500, 16'h0123, 16'h0456);
      chk("held_busy_146", BUSY, 1'b0);
      while (cyc < r0 + 146) @(negedge CLK);
      chk("held_busy_late", BUSY, 1'b0);
      settle();
      compare_all("held");

      // ---- pending request plus a dropped third ----
      r0 = cyc + 1;
      request(1, 16'h0321, 16'h0654);
      request_at(r0 + 60, 1, 16'h0BEE, 16'h0CAF);
      request_at(r0 + 70, 1, 16'h0DAD, 16'h0FAD);
      settle();
      compare_all("pending");

      // ---- leading-bit error on the voltage channel ----
      request(1, 16'h0777, 16'h4999);
      settle();
      compare_all("leadzero");

      // ---- randomized requests ----
      for (int n = 0; n < 25; n++) begin
         int gap;
         int hold;
         gap  = $urandom_range(1, 170);
         hold = $urandom_range(1, 3);
         repeat (gap) @(negedge CLK);
         request(hold, rnd_word(), rnd_word());
      end
      settle();
      compare_all("random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
